// File: rtl/pipelined_addsub.sv
// Pipelined add/sub, carry split into STAGES ripple segments; latency STAGES cycles.
// Global stall: every stage holds while out_valid & ~out_ready, and in_ready drops.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    input  logic             subtract_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int SEG   = WIDTH / STAGES;
    localparam int NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

    logic             advance;
    logic             vld_q [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic [WIDTH-1:0] a_q   [NPIPE];
    logic [WIDTH-1:0] b_q   [NPIPE];
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] r_i;
        logic [WIDTH-1:0] r_nxt;
        logic             c_i;
        logic             v_i;
        logic [SEG:0]     seg_sum;

        if (k == 0) begin : g_first
            // Subtract is A + ~B + ~borrow_in, so invert both here once.
            assign a_i = operand_a;
            assign b_i = subtract_mode ? ~operand_b : operand_b;
            assign c_i = carry_in ^ subtract_mode;
            assign r_i = '0;
            assign v_i = in_valid;
        end else begin : g_next
            assign a_i = a_q[k-1];
            assign b_i = b_q[k-1];
            assign c_i = cy_q[k-1];
            assign r_i = res_q[k-1];
            assign v_i = vld_q[k-1];
        end

        assign seg_sum = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_i};

        always_comb begin
            r_nxt                = r_i;
            r_nxt[k*SEG +: SEG]  = seg_sum[SEG-1:0];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                res_q[k] <= '0;
            end else if (advance) begin
                vld_q[k] <= v_i;
                cy_q[k]  <= seg_sum[SEG];
                res_q[k] <= r_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end else if (advance) begin
                    a_q[k] <= a_i;
                    b_q[k] <= b_i;
                end
            end
        end else begin : g_last
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b1;
                    neg_q  <= 1'b0;
                end else if (advance) begin
                    ovf_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ r_nxt[WIDTH-1] ^ seg_sum[SEG];
                    zero_q <= ~|r_nxt;
                    neg_q  <= r_nxt[WIDTH-1];
                end
            end
        end
    end

    if (STAGES == 1) begin : g_no_pipe
        assign a_q[0] = '0;
        assign b_q[0] = '0;
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign carry_out = cy_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: four width/stage configurations share one stimulus bus.
module tb_pipelined_addsub;
    typedef struct packed {
        logic [63:0] res;
        logic        co;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    localparam int WID [4] = '{32, 8, 16, 64};
    localparam int STG [4] = '{4, 1, 16, 8};

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, carry_in, subtract_mode;
    logic [63:0] op_a, op_b;
    logic [3:0]  in_rdy, out_vld, o_co, o_ovf, o_zero, o_neg;
    logic [63:0] o_res [4];
    logic [31:0] r0;
    logic [7:0]  r1;
    logic [15:0] r2;
    logic [63:0] r3;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign o_res[0] = {32'b0, r0};
    assign o_res[1] = {56'b0, r1};
    assign o_res[2] = {48'b0, r2};
    assign o_res[3] = r3;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .operand_a(op_a[31:0]), .operand_b(op_b[31:0]), .carry_in(carry_in),
        .subtract_mode(subtract_mode), .out_valid(out_vld[0]), .out_ready(out_ready),
        .result(r0), .carry_out(o_co[0]), .overflow(o_ovf[0]), .zero(o_zero[0]),
        .negative(o_neg[0]));
    pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .operand_a(op_a[7:0]), .operand_b(op_b[7:0]), .carry_in(carry_in),
        .subtract_mode(subtract_mode), .out_valid(out_vld[1]), .out_ready(out_ready),
        .result(r1), .carry_out(o_co[1]), .overflow(o_ovf[1]), .zero(o_zero[1]),
        .negative(o_neg[1]));
    pipelined_addsub #(.WIDTH(16), .STAGES(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
        .operand_a(op_a[15:0]), .operand_b(op_b[15:0]), .carry_in(carry_in),
        .subtract_mode(subtract_mode), .out_valid(out_vld[2]), .out_ready(out_ready),
        .result(r2), .carry_out(o_co[2]), .overflow(o_ovf[2]), .zero(o_zero[2]),
        .negative(o_neg[2]));
    pipelined_addsub #(.WIDTH(64), .STAGES(8)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[3]),
        .operand_a(op_a), .operand_b(op_b), .carry_in(carry_in),
        .subtract_mode(subtract_mode), .out_valid(out_vld[3]), .out_ready(out_ready),
        .result(r3), .carry_out(o_co[3]), .overflow(o_ovf[3]), .zero(o_zero[3]),
        .negative(o_neg[3]));

    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic signed [67:0] sx(input logic [63:0] v, input int w);
        logic signed [67:0] t;
        t = $signed({4'b0, v});
        t = t <<< (68 - w);
        return t >>> (68 - w);
    endfunction

    // Reference: unsigned value for result/carry, signed range test for overflow.
    function automatic exp_t ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub);
        logic [67:0]        ua, ub, us;
        logic signed [67:0] sa, sb, ss, smax, smin;
        logic [63:0]        m;
        exp_t               e;
        m    = mask_of(w);
        ua   = {4'b0, a & m};
        ub   = {4'b0, b & m};
        sa   = sx(a, w);
        sb   = sx(b, w);
        smax = (68'sd1 <<< (w - 1)) - 68'sd1;
        smin = -(68'sd1 <<< (w - 1));
        if (!sub) begin
            us   = ua + ub + 68'(cin);
            e.co = (us >= (68'd1 << w));
            ss   = sa + sb + 68'(cin);
        end else begin
            us   = ua - ub - 68'(cin);
            e.co = (ua >= ub + 68'(cin));
            ss   = sa - sb - 68'(cin);
        end
        e.res  = us[63:0] & m;
        e.ovf  = (ss > smax) || (ss < smin);
        e.zero = (e.res == 64'd0);
        e.neg  = e.res[w-1];
        return e;
    endfunction

    function automatic exp_t act_of(input int d);
        return {o_res[d], o_co[d], o_ovf[d], o_zero[d], o_neg[d]};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        exp_t rst_exp;
        rst_exp = '{res: 64'd0, co: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (out_vld[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid d=%0d got %b want 0", d, out_vld[d]);
            end
            n_checks++;
            if (in_rdy[d] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready d=%0d got %b want 1", d, in_rdy[d]);
            end
            n_checks++;
            if (act_of(d) !== rst_exp) begin
                n_fail++; $display("FAIL reset_fields d=%0d got %h want %h", d, act_of(d), rst_exp);
            end
        end
    endtask

    task automatic test_directed(input int d, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
        exp_t e;
        int   lat;
        e = ref_op(WID[d], a, b, cin, sub);
        idle(20);
        @(posedge clk); #1;
        op_a = a; op_b = b; carry_in = cin; subtract_mode = sub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_rdy[d] !== 1'b1) begin
            n_fail++; $display("FAIL dir_in_ready d=%0d got %b want 1", d, in_rdy[d]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_vld[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== STG[d] || out_vld[d] !== 1'b1) begin
            n_fail++; $display("FAIL dir_latency d=%0d got %0d want %0d", d, lat, STG[d]);
        end
        n_checks++;
        if (act_of(d) !== e) begin
            n_fail++; $display("FAIL dir_fields d=%0d a=%h b=%h cin=%b sub=%b got %h want %h",
                               d, a, b, cin, sub, act_of(d), e);
        end
    endtask

    task automatic test_stream(input int n, input bit toggle);
        exp_t q[$];
        exp_t held_v, act;
        bit   held;
        int   sent, got, cyc;
        sent = 0; got = 0; cyc = 0; held = 1'b0;
        idle(20);
        while (got < n && cyc < 5000) begin
            @(posedge clk); #1;
            in_valid      = (sent < n) && (toggle ? ($urandom_range(0, 3) != 0) : 1'b1);
            op_a          = {$urandom(), $urandom()};
            op_b          = {$urandom(), $urandom()};
            carry_in      = 1'($urandom_range(0, 1));
            subtract_mode = 1'($urandom_range(0, 1));
            out_ready     = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            act = act_of(0);
            n_checks++;
            if (in_rdy[0] !== (~out_vld[0] | out_ready)) begin
                n_fail++; $display("FAIL stream_in_ready cyc=%0d got %b want %b",
                                   cyc, in_rdy[0], ~out_vld[0] | out_ready);
            end
            if (held) begin
                n_checks++;
                if (out_vld[0] !== 1'b1 || act !== held_v) begin
                    n_fail++; $display("FAIL stream_hold cyc=%0d got vld=%b %h want vld=1 %h",
                                       cyc, out_vld[0], act, held_v);
                end
            end
            if (in_valid && in_rdy[0]) begin
                q.push_back(ref_op(32, op_a, op_b, carry_in, subtract_mode));
                sent++;
            end
            if (out_vld[0] && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra cyc=%0d got %h want none", cyc, act);
                end else if (act !== q[0]) begin
                    n_fail++; $display("FAIL stream_data #%0d got %h want %h", got, act, q[0]);
                    void'(q.pop_front());
                end else begin
                    void'(q.pop_front());
                end
                got++;
            end
            held   = out_vld[0] && !out_ready;
            held_v = act;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== n) begin
            n_fail++; $display("FAIL stream_count got %0d want %0d", got, n);
        end
        if (!toggle) begin
            n_checks++;
            if (cyc !== n + STG[0]) begin
                n_fail++; $display("FAIL stream_rate cycles got %0d want %0d", cyc, n + STG[0]);
            end
        end
    endtask

    task automatic test_reset_flush();
        exp_t e;
        idle(20);
        repeat (6) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op_a = {$urandom(), $urandom()}; op_b = {$urandom(), $urandom()};
        end
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_vld !== 4'b0) begin
            n_fail++; $display("FAIL flush_after_reset got %b want 0000", out_vld);
        end
        rst_n = 1'b1;
        op_a = 64'h0000_0000_1234_5678; op_b = 64'h0000_0000_0000_1111;
        carry_in = 1'b0; subtract_mode = 1'b1;
        e = ref_op(32, op_a, op_b, carry_in, subtract_mode);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < STG[0]; i++) begin
            n_checks++;
            if (out_vld[0] !== 1'b0) begin
                n_fail++; $display("FAIL flush_quiet cyc=%0d got %b want 0", i, out_vld[0]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_vld[0] !== 1'b1 || act_of(0) !== e) begin
            n_fail++; $display("FAIL flush_first got vld=%b %h want vld=1 %h",
                               out_vld[0], act_of(0), e);
        end
    endtask

    initial begin
        logic [63:0] m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; carry_in = 1'b0; subtract_mode = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            m = mask_of(WID[d]);
            test_directed(d, m, 64'd1, 1'b0, 1'b0);
            test_directed(d, m >> 1, 64'd1, 1'b0, 1'b0);
            test_directed(d, 64'd5, 64'd3, 1'b1, 1'b0);
            test_directed(d, 64'd5, 64'd7, 1'b0, 1'b1);
            test_directed(d, (m >> 1) + 64'd1, 64'd1, 1'b0, 1'b1);
        end
        test_stream(100, 1'b0);
        test_stream(100, 1'b1);
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
